ts_pid_table_ctrl: RTL and testbench

Sequencer for the ts_filter PID block table (8192 x 1-bit, one bit per 13-bit PID). It accepts configuration commands from the USB control path: single-PID set, whole-table fill, and inclusive PID range. It expands each command into a stream of one-entry-per-cycle writes on the table_wr_address/table_data/table_wren port. It sits between the control-endpoint command decoder and ts_filter_inst inside ts_proxy, and is the only writer of the table.

---
 rtl/ts_pid_ctrl_pkg.sv | 10 +
 rtl/ts_pid_table_ctrl.sv | 82 ++++++++
 tb/tb_ts_pid_table_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ts_pid_ctrl_pkg.sv
// ts_pid_ctrl_pkg: shared widths, opcodes and state encoding for the PID table sequencer
package ts_pid_ctrl_pkg;
  localparam int PID_W = 13;
  localparam int TABLE_DEPTH = 1 << PID_W;
  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_SET = 2'd1;
  localparam logic [1:0] OP_FILL = 2'd2;
  localparam logic [1:0] OP_RANGE = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_FINISH} state_t;
endpackage

// File: rtl/ts_pid_table_ctrl.sv
// ts_pid_table_ctrl: expands SET/FILL/RANGE commands (cmd_*) into one-per-cycle table writes (table_*), with busy/done/err status
module ts_pid_table_ctrl
  import ts_pid_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [PID_W-1:0] cmd_pid_lo,
  input  logic [PID_W-1:0] cmd_pid_hi,
  input  logic             cmd_value,
  output logic [PID_W-1:0] table_wr_address,
  output logic             table_data,
  output logic             table_wren,
  output logic             busy,
  output logic             done,
  output logic             err
);
  state_t state;
  logic [PID_W:0] cur, last, cur_nxt, stop;
  logic [PID_W-1:0] first;
  logic start;
  always_comb begin
    first = cmd_op == OP_FILL ? '0 : cmd_pid_lo;
    stop = cmd_op == OP_FILL ? (PID_W+1)'(TABLE_DEPTH-1) :
           cmd_op == OP_SET ? {1'b0, cmd_pid_lo} : {1'b0, cmd_pid_hi};
    start = cmd_valid && state == ST_IDLE &&
            (cmd_op == OP_SET || cmd_op == OP_FILL || (cmd_op == OP_RANGE && cmd_pid_lo <= cmd_pid_hi));
    cur_nxt = cur + (PID_W+1)'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cmd_ready <= 1'b1;
      table_wren <= 1'b0;
      table_wr_address <= '0;
      table_data <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      cur <= '0;
      last <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_WRITE;
            cmd_ready <= 1'b0;
            busy <= 1'b1;
            table_wren <= 1'b1;
            table_wr_address <= first;
            table_data <= cmd_value;
            cur <= {1'b0, first};
            last <= stop;
          end else if (cmd_valid) begin
            done <= cmd_op == OP_NOP;
            err <= cmd_op == OP_RANGE;
          end
        end
        ST_WRITE: begin
          if (cur == last) begin
            state <= ST_FINISH;
            table_wren <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            cur <= cur_nxt;
            table_wr_address <= cur_nxt[PID_W-1:0];
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ts_pid_table_ctrl.sv
// tb_ts_pid_table_ctrl: randomized and directed check of ts_pid_table_ctrl against a trace-queue model
module tb_ts_pid_table_ctrl;
  import ts_pid_ctrl_pkg::*;
  logic clk = 0, reset = 1, cmd_valid = 0, cmd_value = 0;
  logic [1:0] cmd_op = 0;
  logic [PID_W-1:0] cmd_pid_lo = 0, cmd_pid_hi = 0;
  logic cmd_ready, table_data, table_wren, busy, done, err;
  logic [PID_W-1:0] table_wr_address;
  typedef struct packed {
    logic ready;
    logic wren;
    logic [PID_W-1:0] addr;
    logic data;
    logic busy;
    logic done;
    logic err;
  } obs_t;
  obs_t exp_o, q[$];
  bit model_on = 0;
  int vectors = 0, miscompares = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  ts_pid_table_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_pid_lo(cmd_pid_lo), .cmd_pid_hi(cmd_pid_hi), .cmd_value(cmd_value),
    .table_wr_address(table_wr_address), .table_data(table_data), .table_wren(table_wren),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  function automatic void push_run(input int lo, input int hi, input logic v);
    for (int a = lo; a <= hi; a++)
      q.push_back('{ready: 1'b0, wren: 1'b1, addr: PID_W'(a), data: v, busy: 1'b1, done: 1'b0, err: 1'b0});
    q.push_back('{ready: 1'b0, wren: 1'b0, addr: PID_W'(hi), data: v, busy: 1'b0, done: 1'b1, err: 1'b0});
  endfunction
  always @(posedge clk) begin
    obs_t idle;
    if (reset) begin
      q.delete();
      exp_o = '{ready: 1'b1, default: '0};
      model_on = 1;
    end else begin
      idle = '{ready: 1'b1, wren: 1'b0, addr: exp_o.addr, data: exp_o.data, busy: 1'b0, done: 1'b0, err: 1'b0};
      if (cmd_valid && exp_o.ready) begin
        if (cmd_op == OP_NOP) begin
          idle.done = 1'b1;
          q.push_back(idle);
        end else if (cmd_op == OP_SET) push_run(int'(cmd_pid_lo), int'(cmd_pid_lo), cmd_value);
        else if (cmd_op == OP_FILL) push_run(0, TABLE_DEPTH - 1, cmd_value);
        else if (cmd_pid_lo > cmd_pid_hi) begin
          idle.err = 1'b1;
          q.push_back(idle);
        end else push_run(int'(cmd_pid_lo), int'(cmd_pid_hi), cmd_value);
      end
      exp_o = q.size() != 0 ? q.pop_front() : idle;
    end
    wr_cnt += int'(table_wren);
    done_cnt += int'(done);
    err_cnt += int'(err);
  end
  always @(negedge clk) begin
    obs_t act;
    if (model_on) begin
      act = {cmd_ready, table_wren, table_wr_address, table_data, busy, done, err};
      vectors++;
      if (act !== exp_o) begin
        miscompares++;
        $display("FAIL trace t=%0t got rdy=%b wren=%b addr=%h data=%b busy=%b done=%b err=%b required rdy=%b wren=%b addr=%h data=%b busy=%b done=%b err=%b",
                 $time, act.ready, act.wren, act.addr, act.data, act.busy, act.done, act.err,
                 exp_o.ready, exp_o.wren, exp_o.addr, exp_o.data, exp_o.busy, exp_o.done, exp_o.err);
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      miscompares++;
      $display("FAIL ready-timeout: got cmd_ready=0 required 1");
    end
  endtask
  task automatic send(input logic [1:0] op, input int lo, input int hi, input logic v);
    cmd_valid = 1;
    cmd_op = op;
    cmd_pid_lo = PID_W'(lo);
    cmd_pid_hi = PID_W'(hi);
    cmd_value = v;
    wait_ready();
    @(negedge clk);
    cmd_valid = 0;
    cmd_op = 2'($urandom);
    cmd_pid_lo = PID_W'($urandom);
    cmd_pid_hi = PID_W'($urandom);
    cmd_value = 1'($urandom);
  endtask
  initial begin
    int w0, d0, e0, wc, n, fills, lo, hi;
    logic [PID_W-1:0] lo_hold;
    logic v_hold;
    logic [1:0] op;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_wren", table_wren, 0);
    chk("rst_addr", table_wr_address, 0);
    chk("rst_status", {busy, done, err, table_data}, 0);
    reset = 0;
    @(negedge clk);
    send(OP_SET, 'h176, 0, 1);
    chk("set_wren", table_wren, 1);
    chk("set_addr", table_wr_address, 'h176);
    chk("set_data", table_data, 1);
    @(negedge clk);
    chk("set_done", {done, table_wren, cmd_ready}, 3'b100);
    @(negedge clk);
    chk("set_ready", cmd_ready, 1);
    w0 = wr_cnt;
    send(OP_FILL, 0, 0, 0);
    wait_ready();
    repeat (2) @(negedge clk);
    chk("fill_writes", wr_cnt - w0, 8192);
    chk("fill_last_addr", table_wr_address, 'h1FFF);
    w0 = wr_cnt;
    d0 = done_cnt;
    send(OP_RANGE, 'h1FE, 'h1FF, 1);
    wait_ready();
    repeat (2) @(negedge clk);
    chk("range2_writes", wr_cnt - w0, 2);
    chk("range2_done", done_cnt - d0, 1);
    w0 = wr_cnt;
    d0 = done_cnt;
    e0 = err_cnt;
    send(OP_RANGE, 'h1FF, 'h1FE, 1);
    chk("bad_range_err", {err, done}, 2'b10);
    repeat (2) @(negedge clk);
    chk("bad_range_writes", wr_cnt - w0, 0);
    chk("bad_range_errcnt", err_cnt - e0, 1);
    chk("bad_range_nodone", done_cnt - d0, 0);
    send(OP_RANGE, 'h1FFF, 'h1FFF, 0);
    chk("top_addr", {table_wren, table_wr_address}, {1'b1, 13'h1FFF});
    @(negedge clk);
    chk("top_nowrap", {done, table_wren}, 2'b10);
    wait_ready();
    send(OP_SET, 0, 0, 1);
    chk("set0_addr", {table_wren, table_wr_address}, {1'b1, 13'h0});
    wait_ready();
    send(OP_FILL, 0, 0, 1);
    repeat (99) @(negedge clk);
    chk("fill100_addr", table_wr_address, 99);
    d0 = done_cnt;
    reset = 1;
    @(negedge clk);
    chk("abort_state", {table_wren, cmd_ready, done, busy}, 4'b0100);
    reset = 0;
    @(negedge clk);
    chk("abort_nodone", done_cnt - d0, 0);
    send(OP_SET, 5, 0, 1);
    chk("after_abort", {table_wren, table_wr_address, table_data}, {1'b1, 13'd5, 1'b1});
    wait_ready();
    send(OP_RANGE, 10, 20, 1);
    wc = 0;
    n = 0;
    while (!cmd_ready && n < 100) begin
      wc += int'(table_wren);
      cmd_valid = 1;
      cmd_op = OP_SET;
      cmd_pid_lo = PID_W'($urandom);
      cmd_value = 1'($urandom);
      @(negedge clk);
      n++;
    end
    chk("held_writes", wc, 11);
    lo_hold = cmd_pid_lo;
    v_hold = cmd_value;
    @(negedge clk);
    cmd_valid = 0;
    chk("held_accept", {table_wren, table_wr_address, table_data}, {1'b1, lo_hold, v_hold});
    fills = 0;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      if (op == OP_FILL && fills > 0) op = OP_SET;
      if (op == OP_FILL) fills++;
      lo = int'($urandom_range(0, TABLE_DEPTH - 1));
      hi = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, TABLE_DEPTH - 1)) : lo + int'($urandom_range(0, 20));
      if (hi > TABLE_DEPTH - 1) hi = TABLE_DEPTH - 1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(op, lo, hi, 1'($urandom));
    end
    wait_ready();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
